// File: rtl/fetch_pkg.sv
// Shared state encoding and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Generator/memory/decoder signals of the fetch stage.
// FETCH_STATS_EN adds the stall/bubble statistics counters.
interface instruction_fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] PC;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              PC_enable;
  logic [DATA_W-1:0] IR;
  logic [ADDR_W-1:0] IR_PC;
  logic              IR_valid;
  logic              dec_ready;
`ifdef FETCH_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  // Fetch stage side.
  modport master (
    input  PC, flush, mem_ready, mem_rvalid, mem_rdata, dec_ready,
`ifdef FETCH_STATS_EN
    output stall_cnt, bubble_cnt,
`endif
    output mem_req, mem_addr, PC_enable, IR, IR_PC, IR_valid
  );

  // Generator, memory and decoder side.
  modport slave (
    output PC, flush, mem_ready, mem_rvalid, mem_rdata, dec_ready,
`ifdef FETCH_STATS_EN
    input  stall_cnt, bubble_cnt,
`endif
    input  mem_req, mem_addr, PC_enable, IR, IR_PC, IR_valid
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// In-order FIFO holding fetched instructions with their addresses.
// Clear wins over push/pop; push while full is allowed only alongside a pop.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  parameter  int unsigned DEPTH  = DEF_BUF_DEPTH,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  input  logic              clear,
  output logic [CNT_W-1:0]  count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_addr
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= push_data;
        addr_q[wr_ptr_q] <= push_addr;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = data_q[rd_ptr_q];
  assign head_addr  = addr_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: issues one outstanding fetch at a time, buffers responses and
// squashes in-flight fetches on redirect. FETCH_STATS_EN adds stall/bubble counters.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                       Clock,
  input  logic                       Reset,
  instruction_fetch_stage_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned CMP_W = CNT_W + 1;

  fetch_state_e      state_q;
  logic              outstanding_q;
  logic [ADDR_W-1:0] inflight_addr_q;
  logic [CNT_W-1:0]  buf_count;
  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;
  logic              pop_c;
  logic              push_c;
  logic              req_c;
  logic              accept_c;

  // Request only if the reply is guaranteed a free slot after this cycle's pop.
  always_comb begin
    pop_c  = head_valid & bus.dec_ready;
    push_c = (state_q == ST_RUN) & bus.mem_rvalid & outstanding_q & ~bus.flush;
    req_c  = 1'b0;
    if ((state_q == ST_RUN) && !bus.flush && (!outstanding_q || bus.mem_rvalid)) begin
      req_c = (CMP_W'(buf_count) + CMP_W'(outstanding_q)) <
              (CMP_W'(BUF_DEPTH) + CMP_W'(pop_c));
    end
    accept_c = req_c & bus.mem_ready;
  end

  assign bus.mem_req   = req_c;
  assign bus.mem_addr  = bus.PC;
  assign bus.PC_enable = accept_c;

  // State machine and outstanding-request tracking.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q         <= ST_IDLE;
      outstanding_q   <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_q <= ST_RUN;
        ST_RUN:    state_q <= ST_RUN;
        ST_SQUASH: if (bus.mem_rvalid) state_q <= ST_RUN;
        default:   state_q <= ST_IDLE;
      endcase
      if (bus.flush) begin
        state_q       <= (outstanding_q && !bus.mem_rvalid) ? ST_SQUASH : ST_RUN;
        outstanding_q <= outstanding_q & ~bus.mem_rvalid;
      end else if (accept_c) begin
        outstanding_q   <= 1'b1;
        inflight_addr_q <= bus.mem_addr;
      end else if (bus.mem_rvalid) begin
        outstanding_q <= 1'b0;
      end
    end
  end

  fetch_skid_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .Clock      (Clock),
    .Reset      (Reset),
    .push       (push_c),
    .push_data  (bus.mem_rdata),
    .push_addr  (inflight_addr_q),
    .pop        (pop_c),
    .clear      (bus.flush),
    .count      (buf_count),
    .head_valid (head_valid),
    .head_data  (head_data),
    .head_addr  (head_addr)
  );

  assign bus.IR       = head_data;
  assign bus.IR_PC    = head_addr;
  assign bus.IR_valid = head_valid;

`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Saturating decoder stall and fetch bubble counters.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (head_valid && !bus.dec_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bus.dec_ready && !head_valid && (state_q == ST_RUN) && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule
